// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_decoder
// Description : VGA raster receiver. Measures HS/VS timing, locks onto a
//               stable raster and regenerates X/Y coordinates plus a
//               display-enable for downstream capture/overlay logic.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2,
    parameter int H_TIMEOUT   = 2047
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_HS,
    input  logic        vga_VS,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic        display,
    output logic        locked,
    output logic [10:0] h_total,
    output logic [10:0] v_total,
    output logic [10:0] hs_width,
    output logic [10:0] vs_width
);

    localparam logic [10:0] C_H_START   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] C_H_END     = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] C_V_START   = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] C_V_END     = 11'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [10:0] C_H_TIMEOUT = 11'(H_TIMEOUT);
    localparam logic [10:0] C_LOCK      = 11'(LOCK_FRAMES);
    localparam logic [10:0] C_CNT_MAX   = 11'h7FF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic        r_hs_d, r_vs_d;
    logic        w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
    logic [10:0] r_h_cnt, r_v_cnt, r_hs_low, r_vs_low;
    logic [10:0] w_line_len, w_frame_len;
    logic        w_line_mis, w_frame_mis, w_restart;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_h_ref, w_h_ref_nxt;
    logic [10:0] r_v_ref, w_v_ref_nxt;
    logic [10:0] r_good, w_good_nxt;
    logic        r_h_ref_valid, w_h_ref_valid_nxt;
    logic        r_line_bad, w_line_bad_nxt;

    assign w_hs_fall   = r_hs_d & ~vga_HS;
    assign w_hs_rise   = ~r_hs_d & vga_HS;
    assign w_vs_fall   = r_vs_d & ~vga_VS;
    assign w_vs_rise   = ~r_vs_d & vga_VS;
    assign w_line_len  = r_h_cnt + 11'd1;
    assign w_frame_len = r_v_cnt + {10'd0, w_hs_fall};
    assign w_line_mis  = w_hs_fall && (w_line_len != r_h_ref);
    assign w_frame_mis = (w_frame_len != r_v_ref);
    // A coincident bad line on the frame edge must also restart acquisition
    assign w_restart   = r_line_bad || (r_h_ref_valid && w_line_mis) || !r_h_ref_valid
                         || ((r_good != 11'd0) && w_frame_mis);
    assign locked      = (r_state == LOCKED);

    // Sync history; reset high so a quiet line produces no edge after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_d <= 1'b1;
            r_vs_d <= 1'b1;
        end else begin
            r_hs_d <= vga_HS;
            r_vs_d <= vga_VS;
        end
    end

    // Horizontal position counter and line-length / HS-width measurement
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt  <= '0;
            h_total  <= '0;
            r_hs_low <= '0;
            hs_width <= '0;
        end else begin
            if (w_hs_fall) begin
                r_h_cnt <= '0;
                h_total <= w_line_len;
            end else if (r_h_cnt != C_H_TIMEOUT) begin
                r_h_cnt <= r_h_cnt + 11'd1;
            end
            if (!vga_HS) begin
                if (r_hs_low != C_CNT_MAX)
                    r_hs_low <= r_hs_low + 11'd1;
            end else begin
                if (w_hs_rise)
                    hs_width <= r_hs_low;
                r_hs_low <= '0;
            end
        end
    end

    // Line counter and frame-length / VS-width (in lines) measurement
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v_cnt  <= '0;
            v_total  <= '0;
            r_vs_low <= '0;
            vs_width <= '0;
        end else begin
            if (w_vs_fall) begin
                r_v_cnt <= '0;
                v_total <= w_frame_len;
            end else if (w_hs_fall) begin
                r_v_cnt <= r_v_cnt + 11'd1;
            end
            if (!vga_VS) begin
                if (w_hs_fall && (r_vs_low != C_CNT_MAX))
                    r_vs_low <= r_vs_low + 11'd1;
            end else begin
                if (w_vs_rise)
                    vs_width <= r_vs_low;
                r_vs_low <= '0;
            end
        end
    end

    // Lock FSM state and reference registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= SEARCH;
            r_h_ref       <= '0;
            r_v_ref       <= '0;
            r_good        <= '0;
            r_h_ref_valid <= 1'b0;
            r_line_bad    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_h_ref       <= w_h_ref_nxt;
            r_v_ref       <= w_v_ref_nxt;
            r_good        <= w_good_nxt;
            r_h_ref_valid <= w_h_ref_valid_nxt;
            r_line_bad    <= w_line_bad_nxt;
        end
    end

    // Lock FSM next-state: learn line length, then require matching frames
    always_comb begin
        w_state_nxt       = r_state;
        w_h_ref_nxt       = r_h_ref;
        w_v_ref_nxt       = r_v_ref;
        w_good_nxt        = r_good;
        w_h_ref_valid_nxt = r_h_ref_valid;
        w_line_bad_nxt    = r_line_bad;
        case (r_state)
            SEARCH: begin
                if (w_vs_fall) begin
                    w_state_nxt       = TRACK;
                    w_good_nxt        = '0;
                    w_h_ref_valid_nxt = 1'b0;
                    w_line_bad_nxt    = 1'b0;
                end
            end
            TRACK: begin
                if (w_hs_fall) begin
                    if (!r_h_ref_valid) begin
                        w_h_ref_nxt       = w_line_len;
                        w_h_ref_valid_nxt = 1'b1;
                    end else if (w_line_mis) begin
                        w_line_bad_nxt = 1'b1;
                    end
                end
                if (w_vs_fall) begin
                    if (w_restart) begin
                        w_good_nxt        = '0;
                        w_h_ref_valid_nxt = 1'b0;
                        w_line_bad_nxt    = 1'b0;
                    end else begin
                        w_v_ref_nxt = w_frame_len;
                        w_good_nxt  = r_good + 11'd1;
                        if ((r_good + 11'd1) >= C_LOCK)
                            w_state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_line_mis || (w_vs_fall && w_frame_mis) || (r_h_cnt == C_H_TIMEOUT))
                    w_state_nxt = SEARCH;
            end
            default: w_state_nxt = SEARCH;
        endcase
    end

    // Registered coordinate regeneration inside the active window
    always_ff @(posedge clk) begin
        if (reset) begin
            X       <= '0;
            Y       <= '0;
            display <= 1'b0;
        end else if ((r_state == LOCKED) &&
                     (r_h_cnt >= C_H_START) && (r_h_cnt < C_H_END) &&
                     (r_v_cnt >= C_V_START) && (r_v_cnt < C_V_END)) begin
            X       <= 10'(r_h_cnt - C_H_START);
            Y       <= 10'(r_v_cnt - C_V_START);
            display <= 1'b1;
        end else begin
            X       <= '0;
            Y       <= '0;
            display <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_decoder
// Description : Self-checking bench for vga_sync_decoder on a scaled raster
//               (32 clocks x 13 lines). Expected coordinates are queued as
//               each pixel is driven and compared when the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

    localparam int H_ACTIVE  = 20;
    localparam int H_SYNC    = 6;
    localparam int H_BACK    = 4;
    localparam int H_TOT     = 32;
    localparam int V_ACTIVE  = 6;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 3;
    localparam int V_TOT     = 13;
    localparam int H_TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vga_HS = 1'b1;
    logic        vga_VS = 1'b1;
    logic [9:0]  X, Y;
    logic        display, locked;
    logic [10:0] h_total, v_total, hs_width, vs_width;

    vga_sync_decoder #(
        .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .LOCK_FRAMES(2), .H_TIMEOUT(H_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .vga_HS(vga_HS), .vga_VS(vga_VS),
        .X(X), .Y(Y), .display(display), .locked(locked),
        .h_total(h_total), .v_total(v_total),
        .hs_width(hs_width), .vs_width(vs_width)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       disp;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    logic exp_lock = 1'b0;
    int   acq = 0;
    int   disp_seen = 0;
    logic glitch_pend = 1'b0;

    // One pixel clock: drive syncs, queue expected coordinates, check outputs
    task automatic drive(input logic hs, input logic vs, input int col, input int row, input logic rst);
        exp_t e;
        vga_HS = hs;
        vga_VS = vs;
        reset  = rst;
        if (!rst) begin
            e.disp = exp_lock && (col >= H_SYNC + H_BACK) && (col < H_SYNC + H_BACK + H_ACTIVE)
                     && (row >= V_SYNC + V_BACK) && (row < V_SYNC + V_BACK + V_ACTIVE);
            e.x = e.disp ? 10'(col - (H_SYNC + H_BACK)) : 10'd0;
            e.y = e.disp ? 10'(row - (V_SYNC + V_BACK)) : 10'd0;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            sb_q.delete();
            checks++;
            if ({X, Y, display, locked, h_total, v_total, hs_width, vs_width} !== '0)
                $display("FAIL reset_outputs: X=%0d Y=%0d disp=%b lock=%b ht=%0d vt=%0d hw=%0d vw=%0d, required all 0",
                         X, Y, display, locked, h_total, v_total, hs_width, vs_width);
            else
                passed++;
        end else begin
            checks++;
            if (locked !== exp_lock)
                $display("FAIL locked at col=%0d row=%0d: got %b required %b", col, row, locked, exp_lock);
            else
                passed++;
            if (sb_q.size() >= 2) begin
                e = sb_q.pop_front();
                checks++;
                if ({display, X, Y} !== e)
                    $display("FAIL coords near col=%0d row=%0d: got disp=%b X=%0d Y=%0d required disp=%b X=%0d Y=%0d",
                             col, row, display, X, Y, e.disp, e.x, e.y);
                else
                    passed++;
                if (display === 1'b1)
                    disp_seen++;
            end
        end
    endtask

    // Generate rows of a raster frame with optional stretched line or reset
    task automatic gen_frame(input int glitch_row, input int rst_row, input int rst_col, input int nrows);
        int len;
        for (int r = 0; r < nrows; r++) begin
            len = (r == glitch_row) ? H_TOT + 1 : H_TOT;
            for (int c = 0; c < len; c++) begin
                if (c == 0) begin
                    if (glitch_pend) begin
                        exp_lock    = 1'b0;
                        acq         = 0;
                        glitch_pend = 1'b0;
                    end else if (r == 0 && !exp_lock) begin
                        acq++;
                        if (acq == 3)
                            exp_lock = 1'b1;
                    end
                end
                if (r == rst_row && c == rst_col) begin
                    exp_lock = 1'b0;
                    acq      = 0;
                    drive(1'b1, 1'b1, c, r, 1'b1);
                end else begin
                    drive(c >= H_SYNC, r >= V_SYNC, c, r, 1'b0);
                end
            end
            if (r == glitch_row)
                glitch_pend = 1'b1;
        end
    endtask

    task automatic check_val(input string name, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got !== want)
            $display("FAIL %s: got %0d required %0d", name, got, want);
        else
            passed++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            drive((i % 2) == 0, (i % 2) == 1, 40, 0, 1'b1);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b1, 40, 0, 1'b0);
        check_val("h_total_after_reset", h_total, 11'd0);
        check_val("v_total_after_reset", v_total, 11'd0);
        check_val("hs_width_after_reset", hs_width, 11'd0);
        check_val("vs_width_after_reset", vs_width, 11'd0);
    endtask

    task automatic test_lock();
        gen_frame(-1, -1, -1, V_TOT);
        gen_frame(-1, -1, -1, V_TOT);
        check_val("locked_before_third_vs", {10'd0, locked}, 11'd0);
        gen_frame(-1, -1, -1, V_TOT);
        check_val("locked_after_acquire", {10'd0, locked}, 11'd1);
        check_val("h_total", h_total, 11'(H_TOT));
        check_val("v_total", v_total, 11'(V_TOT));
        check_val("hs_width", hs_width, 11'(H_SYNC));
        check_val("vs_width", vs_width, 11'(V_SYNC));
    endtask

    task automatic test_active_window();
        disp_seen = 0;
        gen_frame(-1, -1, -1, V_TOT);
        check_val("display_pixel_count", 11'(disp_seen), 11'(H_ACTIVE * V_ACTIVE));
    endtask

    task automatic test_timing_glitch();
        gen_frame(6, -1, -1, V_TOT);
        check_val("locked_after_glitch", {10'd0, locked}, 11'd0);
        gen_frame(-1, -1, -1, V_TOT);
        gen_frame(-1, -1, -1, V_TOT);
        gen_frame(-1, -1, -1, V_TOT);
        check_val("relock_after_glitch", {10'd0, locked}, 11'd1);
    endtask

    task automatic test_sync_loss();
        gen_frame(-1, -1, -1, 4);
        for (int c = H_TOT; c <= H_TIMEOUT + 10; c++) begin
            if (c == H_TIMEOUT + 1) begin
                exp_lock = 1'b0;
                acq      = 0;
            end
            drive(1'b1, 1'b1, c, 3, 1'b0);
        end
        check_val("h_total_holds", h_total, 11'(H_TOT));
        check_val("hs_width_holds", hs_width, 11'(H_SYNC));
        gen_frame(-1, -1, -1, V_TOT);
        gen_frame(-1, -1, -1, V_TOT);
        gen_frame(-1, -1, -1, V_TOT);
        check_val("relock_after_loss", {10'd0, locked}, 11'd1);
    endtask

    task automatic test_reset_mid_frame();
        gen_frame(-1, 7, 15, V_TOT);
        gen_frame(-1, -1, -1, V_TOT);
        gen_frame(-1, -1, -1, V_TOT);
        check_val("no_early_relock", {10'd0, locked}, 11'd0);
        gen_frame(-1, -1, -1, V_TOT);
        check_val("relock_after_reset", {10'd0, locked}, 11'd1);
        check_val("h_total_after_relock", h_total, 11'(H_TOT));
    endtask

    initial begin
        test_reset();
        test_lock();
        test_active_window();
        test_timing_glitch();
        test_sync_loss();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
